hilo_mdu: RTL and testbench

HILO_MDU -- requirements
Module: hilo_mdu

---
 rtl/hilo_mdu.sv | 162 ++++++++++++++++
 tb/tb_hilo_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: single-cycle multiply/accumulate, iterative
// restoring divide, and MTHI/MTLO direct writes with read forwarding.
module hilo_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          MADD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             hiWtCe,
  input  logic             loWtCe,
  input  logic [WIDTH-1:0] hiWtData,
  input  logic [WIDTH-1:0] loWtData,
  output logic [WIDTH-1:0] hiRdData,
  output logic [WIDTH-1:0] loRdData,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic                 mul_sgn, div_sgn, go_mul, go_div, ge;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, hilo_cur, acc;
  logic [WIDTH:0]       sh, trial;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    go_div  = start && (op[2:1] == 2'b01);
    go_mul  = start && ((op[2:1] == 2'b00) || (MADD_EN && op[2]));
    div_sgn = ~op[0];

    // Multiply uses captured operands; accumulate sees HI/LO as of the writeback edge.
    mul_sgn  = ~op_q[0];
    ext_a    = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
    ext_b    = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
    prod     = ext_a * ext_b;
    hilo_cur = {hi_q, lo_q};
    if (op_q[2] && !op_q[1])     acc = hilo_cur + prod;
    else if (op_q[2] && op_q[1]) acc = hilo_cur - prod;
    else                         acc = prod;

    // a_q doubles as the dividend/quotient shift register, rem_q as partial remainder.
    sh    = {rem_q, a_q[WIDTH-1]};
    trial = sh - {1'b0, b_q};
    ge    = (sh >= {1'b0, b_q});

    case (state_q)
      IDLE: begin
        if (hiWtCe) hi_d = hiWtData;
        if (loWtCe) lo_d = loWtData;
        if (go_mul) begin
          state_d = MUL;
          op_d    = op;
          a_d     = opA;
          b_d     = opB;
        end else if (go_div) begin
          state_d = DIV;
          op_d    = op;
          cnt_d   = '0;
          rem_d   = '0;
          a_d     = (div_sgn && opA[WIDTH-1]) ? -opA : opA;
          b_d     = (div_sgn && opB[WIDTH-1]) ? -opB : opB;
          qneg_d  = div_sgn & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          rneg_d  = div_sgn & opA[WIDTH-1];
        end
      end
      MUL: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = acc[2*WIDTH-1:WIDTH];
          lo_d   = acc[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (b_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d = IDLE;
          cnt_d   = '0;
          lo_d    = qneg_q ? -a_q : a_q;
          hi_d    = rneg_q ? -rem_q : rem_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          rem_d = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], ge};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign dbz      = dbz_q;
  assign hiRdData = (state_q == IDLE && hiWtCe) ? hiWtData : hi_q;
  assign loRdData = (state_q == IDLE && loWtCe) ? loWtData : lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed literal cases plus randomized
// traffic against a cycle-count/arithmetic reference model.
module tb_hilo_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, hiWtCe, loWtCe;
  logic [2:0]   op;
  logic [W-1:0] opA, opB, hiWtData, loWtData, hiRdData, loRdData;
  logic         busy, done, dbz;

  int errors = 0;
  int checks = 0;

  hilo_mdu #(.WIDTH(W), .MADD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .hiWtCe(hiWtCe), .loWtCe(loWtCe),
    .hiWtData(hiWtData), .loWtData(loWtData),
    .hiRdData(hiRdData), .loRdData(loRdData),
    .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_hi, m_lo, m_a, m_b;
  logic [2:0]   m_op;
  bit           m_busy, m_done, m_dbz;
  int           m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dbz = 0; m_cnt = 0;
  endtask

  function automatic bit is_div(input logic [2:0] o);
    return o[2:1] == 2'b01;
  endfunction

  task automatic model_edge();
    bit d, z;
    logic [63:0] p, hl;
    longint sa, sb;
    d = 0; z = 0;
    if (m_busy) begin
      if (flush) m_busy = 0;
      else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          d = 1;
          sa = longint'($signed(m_a));
          sb = longint'($signed(m_b));
          if (is_div(m_op)) begin
            if (m_b == 0) z = 1;
            else if (m_op[0]) begin
              m_lo = m_a / m_b;
              m_hi = m_a % m_b;
            end else begin
              m_lo = W'(sa / sb);
              m_hi = W'(sa % sb);
            end
          end else begin
            if (m_op[0]) p = {32'b0, m_a} * {32'b0, m_b};
            else         p = 64'(sa * sb);
            hl = {m_hi, m_lo};
            case (m_op[2:1])
              2'b10:   hl = hl + p;
              2'b11:   hl = hl - p;
              default: hl = p;
            endcase
            {m_hi, m_lo} = hl;
          end
        end
      end
    end else begin
      if (hiWtCe) m_hi = hiWtData;
      if (loWtCe) m_lo = loWtData;
      if (start) begin
        m_busy = 1;
        m_op = op; m_a = opA; m_b = opB;
        m_cnt = is_div(op) ? ((opB == 0) ? 1 : W + 1) : 1;
      end
    end
    m_done = d;
    m_dbz  = z;
  endtask

  task automatic compare();
    chk("hiRdData", hiRdData, (!m_busy && hiWtCe) ? hiWtData : m_hi);
    chk("loRdData", loRdData, (!m_busy && loWtCe) ? loWtData : m_lo);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("dbz", dbz, m_dbz);
  endtask

  // Called at a negedge with inputs for the coming edge already driven.
  task automatic tick();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1; op = o; opA = a; opB = b;
    tick();
    start = 0;
  endtask

  task automatic wr(input logic [W-1:0] h, input logic [W-1:0] l);
    hiWtCe = 1; loWtCe = 1; hiWtData = h; loWtData = l;
    tick();
    hiWtCe = 0; loWtCe = 0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'h1;
      4:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 0; start = 0; op = 0; opA = 0; opB = 0; flush = 0;
    hiWtCe = 0; loWtCe = 0; hiWtData = 0; loWtData = 0;
    model_reset();
    #2;
    chk("reset_hi", hiRdData, 0);
    chk("reset_lo", loRdData, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", dbz, 0);
    @(negedge clk);
    rst = 1;

    // Signed / unsigned multiply
    issue(3'd0, 32'hFFFF_FFFF, 32'h2);
    chk("mult_busy", busy, 1);
    tick();
    chk("mult_hi", hiRdData, 32'hFFFF_FFFF);
    chk("mult_lo", loRdData, 32'hFFFF_FFFE);
    chk("mult_done", done, 1);
    issue(3'd1, 32'hFFFF_FFFF, 32'h2);
    tick();
    chk("multu_hi", hiRdData, 32'h0000_0001);
    chk("multu_lo", loRdData, 32'hFFFF_FFFE);

    // Signed divide latency and result
    issue(3'd2, 32'hFFFF_FFF9, 32'h2);
    repeat (32) tick();
    chk("div_busy_last", busy, 1);
    chk("div_nodone_early", done, 0);
    tick();
    chk("div_done", done, 1);
    chk("div_busy_end", busy, 0);
    chk("div_lo", loRdData, 32'hFFFF_FFFD);
    chk("div_hi", hiRdData, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (33) tick();
    chk("divovf_lo", loRdData, 32'h8000_0000);
    chk("divovf_hi", hiRdData, 32'h0);

    // Divide by zero
    wr(32'h1234_5678, 32'h9ABC_DEF0);
    issue(3'd3, 32'h5, 32'h0);
    tick();
    chk("dbz_pulse", dbz, 1);
    chk("dbz_done", done, 1);
    chk("dbz_hi", hiRdData, 32'h1234_5678);
    chk("dbz_lo", loRdData, 32'h9ABC_DEF0);

    // Accumulate
    wr(32'h0, 32'hFFFF_FFFF);
    issue(3'd5, 32'h1, 32'h1);
    tick();
    chk("maddu_hi", hiRdData, 32'h1);
    chk("maddu_lo", loRdData, 32'h0);
    wr(32'h0, 32'h0);
    issue(3'd6, 32'h1, 32'h1);
    tick();
    chk("msub_hi", hiRdData, 32'hFFFF_FFFF);
    chk("msub_lo", loRdData, 32'hFFFF_FFFF);

    // Flush mid-divide
    issue(3'd2, 32'd100, 32'd7);
    repeat (10) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_idle", busy, 0);
    chk("flush_hi", hiRdData, 32'hFFFF_FFFF);
    repeat (30) tick();

    // Async reset mid-divide
    issue(3'd2, 32'd100, 32'd7);
    repeat (10) tick();
    #2 rst = 0;
    model_reset();
    #1;
    chk("rst_hi", hiRdData, 0);
    chk("rst_lo", loRdData, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1;
    repeat (35) tick();
    chk("rst_nowb_lo", loRdData, 0);

    // Forwarding and dropped direct write while busy
    hiWtCe = 1; hiWtData = 32'hAAAA_5555;
    #1 chk("fwd_hi", hiRdData, 32'hAAAA_5555);
    tick();
    hiWtCe = 0;
    issue(3'd3, 32'd10, 32'd3);
    hiWtCe = 1; hiWtData = 32'h1111_1111;
    #1 chk("busy_nofwd", hiRdData, 32'hAAAA_5555);
    tick();
    hiWtCe = 0;
    chk("busy_drop", hiRdData, 32'hAAAA_5555);
    issue(3'd0, 32'd3, 32'd3);  // ignored while busy
    repeat (31) tick();
    chk("divu_rem", hiRdData, 32'h1);
    chk("divu_quo", loRdData, 32'h3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      op       = 3'($urandom);
      opA      = pick();
      opB      = pick();
      flush    = ($urandom_range(0, 40) == 0);
      hiWtCe   = ($urandom_range(0, 7) == 0);
      loWtCe   = ($urandom_range(0, 7) == 0);
      hiWtData = W'($urandom);
      loWtData = W'($urandom);
      tick();
    end
    start = 0; flush = 0; hiWtCe = 0; loWtCe = 0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
